// File: rtl/serial_link_credit_ctrl.sv
// Per-VC credit flow control for the serial link: round-robin payload grant,
// piggybacked credit returns. Optional: SERIAL_LINK_CREDIT_TIMEOUT_EN.
module serial_link_credit_ctrl #(
    parameter int NumVc         = 2,
    parameter int NumCredits    = 16,
    parameter int CreditW       = $clog2(NumCredits + 1),
    parameter int ForceThresh   = 12,
    parameter int TimeoutCycles = 64,
    localparam int VcW          = (NumVc > 1) ? $clog2(NumVc) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NumVc-1:0]           tx_valid_i,
    output logic [NumVc-1:0]           tx_ready_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [VcW-1:0]             out_vc_o,
    output logic                       out_payload_o,
    output logic [CreditW-1:0]         out_credit_o,
    output logic [VcW-1:0]             out_credit_vc_o,
    input  logic                       rx_credit_valid_i,
    input  logic [VcW-1:0]             rx_credit_vc_i,
    input  logic [CreditW-1:0]         rx_credit_i,
    input  logic [NumVc-1:0]           rx_consumed_i,
    output logic [NumVc*CreditW-1:0]   credits_o,
    output logic                       err_o
);

    localparam logic [CreditW-1:0] MaxCr   = CreditW'(NumCredits);
    localparam logic [CreditW-1:0] ForceCr = CreditW'(ForceThresh);

    if (NumVc < 1 || ForceThresh < 1 || ForceThresh > NumCredits ||
        TimeoutCycles < 1) begin : g_param_err
        $error("serial_link_credit_ctrl: illegal parameter set");
    end

    logic [CreditW-1:0] avail_q [NumVc];
    logic [CreditW-1:0] avail_d [NumVc];
    logic [CreditW-1:0] pend_q  [NumVc];
    logic [CreditW-1:0] pend_d  [NumVc];

    logic [VcW-1:0]     ptr_tx_q;
    logic [VcW-1:0]     ptr_tx_d;
    logic [VcW-1:0]     ptr_cr_q;
    logic [VcW-1:0]     ptr_cr_d;
    logic               err_q;
    logic               err_d;

    logic [NumVc-1:0]   elig;
    logic [NumVc-1:0]   pend_nz;
    logic [NumVc-1:0]   tx_sel;
    logic [NumVc-1:0]   sent;
    logic [NumVc-1:0]   cleared;
    logic [NumVc-1:0]   rx_hit;

    logic               tx_any;
    logic               pend_any;
    logic               force_cr;
    logic               tmo_fire;
    logic [VcW-1:0]     tx_win;
    logic [VcW-1:0]     cr_vc;
    logic [CreditW-1:0] cr_amt;
    logic               beat_valid;
    logic               hs;
    logic               cr_hs;

    logic [CreditW:0]   a_sum;
    logic [CreditW:0]   p_sum;
    logic               ovf;
    logic               bad_vc;

    // First requester at or after ptr; returns ptr itself when nobody asks.
    function automatic logic [VcW-1:0] rr_pick(
        input logic [NumVc-1:0] req,
        input logic [VcW-1:0]   ptr
    );
        logic [VcW-1:0] pick;
        logic           hit;
        int             idx;
        pick = ptr;
        hit  = 1'b0;
        for (int i = 0; i < NumVc; i++) begin
            idx = (int'(ptr) + i) % NumVc;
            if (!hit && req[VcW'(idx)]) begin
                hit  = 1'b1;
                pick = VcW'(idx);
            end
        end
        return pick;
    endfunction

    function automatic logic [VcW-1:0] rr_next(input logic [VcW-1:0] cur);
        return VcW'((int'(cur) + 1) % NumVc);
    endfunction

    // Per-VC request qualification.
    always_comb begin
        elig     = '0;
        pend_nz  = '0;
        force_cr = 1'b0;
        for (int v = 0; v < NumVc; v++) begin
            elig[v]    = tx_valid_i[v] && (avail_q[v] != '0);
            pend_nz[v] = (pend_q[v] != '0);
            if (pend_q[v] >= ForceCr) begin
                force_cr = 1'b1;
            end
        end
    end

    assign tx_any   = |elig;
    assign pend_any = |pend_nz;
    assign tx_win   = rr_pick(elig, ptr_tx_q);
    assign cr_vc    = rr_pick(pend_nz, ptr_cr_q);
    assign cr_amt   = pend_q[cr_vc];

`ifdef SERIAL_LINK_CREDIT_TIMEOUT_EN
    localparam int TmoW = $clog2(TimeoutCycles + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);

    logic [TmoW-1:0] tmo_q;

    // Idle-credit timer; saturates so the flush request holds until served.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || !pend_any || cr_hs) begin
            tmo_q <= '0;
        end else if (tmo_q != TmoLast) begin
            tmo_q <= tmo_q + TmoW'(1);
        end
    end

    assign tmo_fire = pend_any && (tmo_q == TmoLast);
`else
    assign tmo_fire = 1'b0;
`endif

    assign beat_valid = rst_ni && (tx_any || force_cr || tmo_fire);
    assign hs         = beat_valid && out_ready_i;
    assign cr_hs      = hs && (cr_amt != '0);

    // Decode the handshake into per-VC send/clear/receive strobes.
    always_comb begin
        tx_sel  = '0;
        sent    = '0;
        cleared = '0;
        rx_hit  = '0;
        for (int v = 0; v < NumVc; v++) begin
            tx_sel[v]  = tx_any && (tx_win == VcW'(v));
            sent[v]    = hs && tx_sel[v];
            cleared[v] = hs && (cr_vc == VcW'(v));
            rx_hit[v]  = rx_credit_valid_i &&
                         (rx_credit_vc_i == VcW'(v));
        end
    end

    // Counter arithmetic with clamp-and-flag on overflow.
    always_comb begin
        ovf   = 1'b0;
        a_sum = '0;
        p_sum = '0;
        for (int v = 0; v < NumVc; v++) begin
            a_sum = {1'b0, avail_q[v]};
            if (sent[v]) begin
                a_sum = a_sum - (CreditW+1)'(1);
            end
            if (rx_hit[v]) begin
                a_sum = a_sum + {1'b0, rx_credit_i};
            end
            if (a_sum > {1'b0, MaxCr}) begin
                avail_d[v] = MaxCr;
                ovf        = 1'b1;
            end else begin
                avail_d[v] = a_sum[CreditW-1:0];
            end

            p_sum = cleared[v] ? '0 : {1'b0, pend_q[v]};
            p_sum = p_sum + (CreditW+1)'(rx_consumed_i[v]);
            if (p_sum > {1'b0, MaxCr}) begin
                pend_d[v] = MaxCr;
                ovf       = 1'b1;
            end else begin
                pend_d[v] = p_sum[CreditW-1:0];
            end
        end
        bad_vc = rx_credit_valid_i &&
                 (int'(rx_credit_vc_i) >= NumVc);
        err_d  = err_q | ovf | bad_vc;
    end

    // Round-robin pointers move past a winner only when its beat is taken.
    always_comb begin
        ptr_tx_d = ptr_tx_q;
        ptr_cr_d = ptr_cr_q;
        if (hs && tx_any) begin
            ptr_tx_d = rr_next(tx_win);
        end
        if (cr_hs) begin
            ptr_cr_d = rr_next(cr_vc);
        end
    end

    // State registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int v = 0; v < NumVc; v++) begin
                avail_q[v] <= MaxCr;
                pend_q[v]  <= '0;
            end
            ptr_tx_q <= '0;
            ptr_cr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            for (int v = 0; v < NumVc; v++) begin
                avail_q[v] <= avail_d[v];
                pend_q[v]  <= pend_d[v];
            end
            ptr_tx_q <= ptr_tx_d;
            ptr_cr_q <= ptr_cr_d;
            err_q    <= err_d;
        end
    end

    // Status vector of available credits.
    always_comb begin
        credits_o = '0;
        for (int v = 0; v < NumVc; v++) begin
            credits_o[v*CreditW +: CreditW] = avail_q[v];
        end
    end

    assign tx_ready_o      = (rst_ni && out_ready_i) ? tx_sel : '0;
    assign out_valid_o     = beat_valid;
    assign out_payload_o   = rst_ni && tx_any;
    assign out_vc_o        = (rst_ni && tx_any) ? tx_win : '0;
    assign out_credit_o    = rst_ni ? cr_amt : '0;
    assign out_credit_vc_o = rst_ni ? cr_vc : '0;
    assign err_o           = err_q;

endmodule

// File: tb/tb_serial_link_credit_ctrl.sv
// Scoreboard bench for serial_link_credit_ctrl (NumVc=2, 16 credits).
// Expected beats are queued by stimulus and popped by a handshake monitor.
module tb_serial_link_credit_ctrl;

    localparam int NumVc   = 2;
    localparam int NumCr   = 16;
    localparam int CreditW = 5;
    localparam int VcW     = 1;

    typedef struct {
        logic               payload;
        logic [VcW-1:0]     vc;
        logic [CreditW-1:0] credit;
        logic [VcW-1:0]     cvc;
        logic [NumVc-1:0]   txr;
    } beat_t;

    logic                     clk_i = 1'b0;
    logic                     rst_ni;
    logic [NumVc-1:0]         tx_valid_i;
    logic [NumVc-1:0]         tx_ready_o;
    logic                     out_valid_o;
    logic                     out_ready_i;
    logic [VcW-1:0]           out_vc_o;
    logic                     out_payload_o;
    logic [CreditW-1:0]       out_credit_o;
    logic [VcW-1:0]           out_credit_vc_o;
    logic                     rx_credit_valid_i;
    logic [VcW-1:0]           rx_credit_vc_i;
    logic [CreditW-1:0]       rx_credit_i;
    logic [NumVc-1:0]         rx_consumed_i;
    logic [NumVc*CreditW-1:0] credits_o;
    logic                     err_o;

    beat_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;
    int    beat_no  = 0;

    serial_link_credit_ctrl #(
        .NumVc        (NumVc),
        .NumCredits   (NumCr),
        .CreditW      (CreditW),
        .ForceThresh  (12),
        .TimeoutCycles(64)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .tx_valid_i       (tx_valid_i),
        .tx_ready_o       (tx_ready_o),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .out_vc_o         (out_vc_o),
        .out_payload_o    (out_payload_o),
        .out_credit_o     (out_credit_o),
        .out_credit_vc_o  (out_credit_vc_o),
        .rx_credit_valid_i(rx_credit_valid_i),
        .rx_credit_vc_i   (rx_credit_vc_i),
        .rx_credit_i      (rx_credit_i),
        .rx_consumed_i    (rx_consumed_i),
        .credits_o        (credits_o),
        .err_o            (err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int p, input int vc, input int cr,
                        input int cvc);
        beat_t b;
        b.payload = (p != 0);
        b.vc      = VcW'(vc);
        b.credit  = CreditW'(cr);
        b.cvc     = VcW'(cvc);
        b.txr     = (p != 0) ? NumVc'(1 << vc) : '0;
        exp_q.push_back(b);
    endtask

    task automatic clear_in();
        tx_valid_i        = '0;
        rx_credit_valid_i = 1'b0;
        rx_credit_vc_i    = '0;
        rx_credit_i       = '0;
        rx_consumed_i     = '0;
    endtask

    task automatic do_reset();
        clear_in();
        rst_ni      = 1'b0;
        out_ready_i = 1'b1;
        tx_valid_i  = 2'b11;
        step(2);
        chk("rst_valid", 32'(out_valid_o), 32'd0);
        chk("rst_ready", 32'(tx_ready_o), 32'd0);
        chk("rst_cred0", 32'(credits_o[4:0]), 32'd16);
        chk("rst_cred1", 32'(credits_o[9:5]), 32'd16);
        chk("rst_err", 32'(err_o), 32'd0);
        rst_ni     = 1'b1;
        tx_valid_i = '0;
    endtask

    // Handshake monitor: every accepted beat must match the queue head.
    initial begin
        beat_t e;
        logic  ok;
        forever begin
            @(negedge clk_i);
            if (rst_ni === 1'b1 && out_valid_o && out_ready_i) begin
                checks++;
                beat_no++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL beat%0d unexpected: got p=%0d vc=%0d cr=%0d cvc=%0d expected none",
                             beat_no, out_payload_o, out_vc_o,
                             out_credit_o, out_credit_vc_o);
                end else begin
                    e  = exp_q.pop_front();
                    ok = (out_payload_o == e.payload) &&
                         (out_vc_o == e.vc) &&
                         (out_credit_o == e.credit) &&
                         (tx_ready_o == e.txr) &&
                         (e.credit == '0 || out_credit_vc_o == e.cvc);
                    if (!ok) begin
                        failures++;
                        $display("FAIL beat%0d: got p=%0d vc=%0d cr=%0d cvc=%0d rdy=%b expected p=%0d vc=%0d cr=%0d cvc=%0d rdy=%b",
                                 beat_no, out_payload_o, out_vc_o,
                                 out_credit_o, out_credit_vc_o, tx_ready_o,
                                 e.payload, e.vc, e.credit, e.cvc, e.txr);
                    end
                end
            end
        end
    end

    initial begin
        clear_in();
        rst_ni      = 1'b0;
        out_ready_i = 1'b0;
        do_reset();

        // Exhaust VC0: exactly 16 grants in 20 cycles.
        for (int i = 0; i < 16; i++) push(1, 0, 0, 0);
        tx_valid_i = 2'b01;
        step(20);
        chk("t1_cred0", 32'(credits_o[4:0]), 32'd0);
        chk("t1_idle", 32'(out_valid_o), 32'd0);
        chk("t1_drain", 32'(exp_q.size()), 32'd0);
        tx_valid_i = '0;

        // Peer returns 5 credits: exactly 5 more grants.
        rx_credit_valid_i = 1'b1;
        rx_credit_vc_i    = 1'b0;
        rx_credit_i       = 5'd5;
        step(1);
        clear_in();
        chk("t2_cred0_5", 32'(credits_o[4:0]), 32'd5);
        for (int i = 0; i < 5; i++) push(1, 0, 0, 0);
        tx_valid_i = 2'b01;
        step(8);
        tx_valid_i = '0;
        chk("t2_cred0_0", 32'(credits_o[4:0]), 32'd0);
        chk("t2_drain", 32'(exp_q.size()), 32'd0);

        // Full refill reaches the limit exactly, no error.
        rx_credit_valid_i = 1'b1;
        rx_credit_i       = 5'd16;
        step(1);
        clear_in();
        chk("t2_refill", 32'(credits_o[4:0]), 32'd16);
        chk("t2_err", 32'(err_o), 32'd0);

        // Alternating grants; a stalled link must not move the pointer.
        do_reset();
        push(1, 0, 0, 0); push(1, 1, 0, 0);
        push(1, 0, 0, 0); push(1, 1, 0, 0);
        tx_valid_i = 2'b11;
        step(4);
        out_ready_i = 1'b0;
        #1;
        chk("t3_stall_rdy", 32'(tx_ready_o), 32'd0);
        chk("t3_stall_vld", 32'(out_valid_o), 32'd1);
        chk("t3_stall_vc", 32'(out_vc_o), 32'd0);
        step(3);
        push(1, 0, 0, 0); push(1, 1, 0, 0);
        out_ready_i = 1'b1;
        step(2);
        tx_valid_i = '0;
        step(1);
        chk("t3_cred0", 32'(credits_o[4:0]), 32'd13);
        chk("t3_cred1", 32'(credits_o[9:5]), 32'd13);
        chk("t3_drain", 32'(exp_q.size()), 32'd0);

        // Forced credit-only beat at 12 pending; handshake-cycle consume kept.
        do_reset();
        push(0, 0, 12, 1);
        rx_consumed_i = 2'b10;
        step(13);
        rx_consumed_i = '0;
        step(1);
        chk("t4_drain_a", 32'(exp_q.size()), 32'd0);
        push(0, 0, 12, 1);
        rx_consumed_i = 2'b10;
        step(11);
        rx_consumed_i = '0;
        step(2);
        chk("t4_drain_b", 32'(exp_q.size()), 32'd0);
        chk("t4_idle", 32'(out_valid_o), 32'd0);

        // Credits piggyback on a VC1 payload beat.
        rx_consumed_i = 2'b01;
        step(3);
        rx_consumed_i = '0;
        push(1, 1, 3, 0);
        tx_valid_i = 2'b10;
        step(1);
        tx_valid_i = '0;
        step(1);
        chk("t4_cred0", 32'(credits_o[4:0]), 32'd16);
        chk("t4_cred1", 32'(credits_o[9:5]), 32'd15);
        chk("t4_drain_c", 32'(exp_q.size()), 32'd0);

        // Send plus return at the limit is fine; excess return is sticky error.
        push(1, 0, 0, 0);
        tx_valid_i        = 2'b01;
        rx_credit_valid_i = 1'b1;
        rx_credit_vc_i    = 1'b0;
        rx_credit_i       = 5'd1;
        step(1);
        clear_in();
        chk("t5_cred0", 32'(credits_o[4:0]), 32'd16);
        chk("t5_err0", 32'(err_o), 32'd0);
        chk("t5_drain", 32'(exp_q.size()), 32'd0);
        rx_credit_valid_i = 1'b1;
        rx_credit_i       = 5'd2;
        step(1);
        clear_in();
        chk("t5_clamp", 32'(credits_o[4:0]), 32'd16);
        chk("t5_err1", 32'(err_o), 32'd1);
        step(3);
        chk("t5_sticky", 32'(err_o), 32'd1);

        // Idle pending credits: flushed at cycle 64 only with the timeout.
        do_reset();
        rx_consumed_i = 2'b01;
        step(3);
        rx_consumed_i = '0;
`ifdef SERIAL_LINK_CREDIT_TIMEOUT_EN
        push(0, 0, 3, 0);
`endif
        step(60);
        chk("t6_early", 32'(out_valid_o), 32'd0);
        step(1);
`ifdef SERIAL_LINK_CREDIT_TIMEOUT_EN
        chk("t6_fire", 32'(out_valid_o), 32'd1);
`else
        chk("t6_nofire", 32'(out_valid_o), 32'd0);
`endif
        step(2);
        chk("t6_drain", 32'(exp_q.size()), 32'd0);
        chk("t6_idle", 32'(out_valid_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
